mem_req_sequencer: RTL and testbench
====================================

// Module: mem_req_sequencer
// PURPOSE
//  Upstream request stage for single-port 16x16 memory. Buffers valid/ready requests in a small FIFO.
//  Drives the memory's en/rd_wr/addr/wr_data pins with the required single-pulse, hold-stable protocol.
//  Captures read data; every request returns exactly one response on a valid/ready channel.
//  Range-checks addresses locally and runs memory error recovery via err_clr.
// PARAMETERS
//  ADDR_WIDTH  4   request/memory address width
//  DATA_WIDTH  16  data width
//  MEM_DEPTH   16  legal addresses 0..MEM_DEPTH-1; addr >= MEM_DEPTH rejected locally
//  FIFO_DEPTH  4   request FIFO entries (power of 2, >= 2)
// PORTS
//  clk             in   1           clock
//  reset           in   1           async active-low reset
//  req_valid       in   1           request present
//  req_ready       out  1           = !fifo_full
//  req_wr          in   1           1 = write, 0 = read
//  req_addr        in   ADDR_WIDTH  target address
//  req_wdata       in   DATA_WIDTH  write data
//  rsp_valid       out  1           response present
//  rsp_ready       in   1           response accepted
//  rsp_wr          out  1           echo of req_wr
//  rsp_rdata       out  DATA_WIDTH  read data; 0 for writes and errors
//  rsp_err         out  1           1 = out-of-range or memory error
//  mem_en          out  1           one-cycle transaction strobe
//  mem_rd_wr       out  1           1 = write, 0 = read
//  mem_addr        out  ADDR_WIDTH  held from ISSUE through CAPTURE
//  mem_wr_data     out  DATA_WIDTH  held from ISSUE through CAPTURE
//  mem_out_wr_en   out  1           loopback enable; = mem_rd_wr during ISSUE/WAIT, else 0
//  mem_rd_data     in   DATA_WIDTH  memory read data (registered in memory)
//  mem_error       in   1           memory error flag (sticky in memory)
//  mem_err_clr     out  1           one-cycle error clear pulse
//  busy            out  1           FSM != IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset (async, reset=0): FSM=IDLE, FIFO empty, all outputs 0 except req_ready=1; mem_error edge reg=0.
//  Reset mid-operation abandons the in-flight op; no response is produced.
//  FIFO: push on req_valid&&req_ready; pop only in IDLE. Simultaneous push+pop is legal at any fill.
//  req_ready does not rise in the same cycle as a pop from full (registered full flag).
//  FSM states: IDLE, ISSUE, WAIT, CAPTURE, ERR_CLR, RESP.
//   IDLE:    if FIFO non-empty, pop into op regs (wr, addr, wdata).
//            addr >= MEM_DEPTH -> RESP, err=1, no memory access.
//            otherwise -> ISSUE.
//   ISSUE:   mem_en=1 for exactly this cycle -> WAIT.
//   WAIT:    mem_en=0, memory executes -> CAPTURE.
//   CAPTURE: read: rsp_rdata<=mem_rd_data; write: rsp_rdata<=0 -> RESP.
//   ERR_CLR: mem_err_clr=1 for one cycle -> RESP with err=1, rdata=0.
//   RESP:    rsp_valid=1, payload stable until rsp_ready; on handshake -> IDLE.
//  mem_error rising edge (prev 0, now 1) during ISSUE/WAIT/CAPTURE -> ERR_CLR; it overrides the normal transition.
//  mem_error level without an edge is ignored.
//  Latency, pop to rsp_valid: 4 cycles (IDLE, ISSUE, WAIT, CAPTURE) for in-range ops; 1 cycle for local reject.
//  Peak throughput: 1 op per 5 cycles with rsp_ready tied 1.
//  Ordering: responses are strictly in request order; one op is in flight at a time.
//  mem_addr/mem_wr_data/mem_rd_wr hold their last value in IDLE/RESP; mem_en=0 outside ISSUE.
// STRUCTURE
//  Package mem_seq_pkg holds:
//   - state enum (3 bits)
//   - default widths ADDR_WIDTH/DATA_WIDTH/MEM_DEPTH
//   - request struct {wr, addr, wdata}
//  Sub-module mem_req_fifo: synchronous FIFO with ptr+1-bit occupancy; full/empty registered.
//  Top level: FSM, op/response regs, mem_error edge detect.
// TESTING
//  1 Write addr 3 data 0xBEEF, then read addr 3, rsp_ready=1 -> mem_en pulses once per op.
//    Write rsp: err=0, rdata=0. Read rsp: rdata=0xBEEF, err=0, 4 cycles after pop.
//  2 Push 5 reqs back-to-back, rsp_ready=0 -> req_ready=0 after 4 accepted plus 1 popped.
//    Release rsp_ready -> all 5 responses return in order, none lost.
//  3 Request addr >= MEM_DEPTH (MEM_DEPTH=12, addr 13) -> no mem_en.
//    rsp_err=1 one cycle after pop.
//  4 Force mem_error 0->1 during WAIT of a read -> mem_err_clr pulses 1 cycle.
//    rsp_err=1, rdata=0; the next op completes normally while mem_error stays 1.
//  5 Assert reset during WAIT -> all outputs 0 within the same cycle, FIFO empty, req_ready=1, no response.
//  6 Hold rsp_ready=0 for 10 cycles in RESP -> rsp payload stable, no new mem_en issued.

Source files
------------

// File: rtl/mem_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_seq_pkg
// Purpose  : Shared types and default sizes for the memory request sequencer.
//            Contains the sequencer state encoding, the default bus widths,
//            the request record and a small state-classification helper.
// Revision : 1.0 - initial release
// ============================================================================
package mem_seq_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_MEM_DEPTH  = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_ERR_CLR = 3'd4,
    S_RESP    = 3'd5
  } state_e;

  typedef struct packed {
    logic                      wr;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } req_t;

  // States in which the memory owns the transaction; a fresh error edge
  // seen here aborts the op into error recovery.
  function automatic logic is_mem_phase(input state_e s);
    return (s == S_ISSUE) || (s == S_WAIT) || (s == S_CAPTURE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_fifo
// Purpose  : Synchronous request FIFO. Pointers carry one extra wrap bit so
//            occupancy is the pointer difference; full and empty are
//            registered so they only change on a clock edge.
// Ports    : clk, reset (async, active-low)
//            push/push_data   - write side (ignored while full)
//            pop/pop_data     - read side, pop_data shows the head entry
//            full/empty       - registered status flags
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_fifo
  import mem_seq_pkg::*;
#(
  parameter int WIDTH = 1 + DEF_ADDR_WIDTH + DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [AW:0]      count_d;
  logic             do_push;
  logic             do_pop;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    // Flags are derived from the next pointers so the registered copies
    // are exact on the following cycle.
    count_d = wr_ptr_d - rd_ptr_d;
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (wr_ptr_d == rd_ptr_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say
  // they were written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
  assign full     = full_q;
  assign empty    = empty_q;

endmodule
`default_nettype wire

// File: rtl/mem_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_sequencer
// Purpose  : Request stage in front of a single-port memory. Buffers
//            valid/ready requests, drives the memory with a one-cycle enable
//            and stable address/data, captures read data and returns exactly
//            one response per request, in order. Out-of-range addresses are
//            rejected locally; a rising memory error triggers a clear pulse
//            and an error response.
// Ports    : clk, reset (async, active-low)
//            req_*        - request channel (valid/ready, wr, addr, wdata)
//            rsp_*        - response channel (valid/ready, wr, rdata, err)
//            mem_en, mem_rd_wr, mem_addr, mem_wr_data, mem_out_wr_en
//                         - memory command pins
//            mem_rd_data, mem_error - memory results
//            mem_err_clr  - one-cycle error clear pulse
//            busy         - op in flight or requests queued
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_wr,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_en,
  output logic                  mem_rd_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_out_wr_en,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_error,
  output logic                  mem_err_clr,
  output logic                  busy
);

  localparam int REQ_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = MEM_DEPTH[ADDR_WIDTH:0];

  // --------------------------------------------------------------------------
  // Request FIFO
  // --------------------------------------------------------------------------
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [REQ_W-1:0] fifo_wdata;
  logic [REQ_W-1:0] fifo_rdata;

  assign fifo_push  = req_valid && !fifo_full;
  assign fifo_wdata = {req_wr, req_addr, req_wdata};

  mem_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  logic                  head_wr;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic                  head_in_range;

  assign head_wr       = fifo_rdata[REQ_W-1];
  assign head_addr     = fifo_rdata[REQ_W-2 -: ADDR_WIDTH];
  assign head_wdata    = fifo_rdata[DATA_WIDTH-1:0];
  assign head_in_range = ({1'b0, head_addr} < MEM_LIMIT);

  // --------------------------------------------------------------------------
  // Sequencer state and operation registers
  // --------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic                  mem_rd_wr_q, mem_rd_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic                  rsp_wr_q, rsp_wr_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  err_prev_q, err_prev_d;
  logic                  err_rise;

  // Only a 0->1 transition counts; the memory flag is sticky, so a level
  // that stays high after recovery must not abort later ops.
  assign err_rise   = mem_error && !err_prev_q;
  assign err_prev_d = mem_error;

  always_comb begin
    state_d       = state_q;
    mem_rd_wr_d   = mem_rd_wr_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    rsp_wr_d      = rsp_wr_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    fifo_pop      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_in_range) begin
            // Memory pins only change when a real access is launched, so
            // a rejected request leaves them at the previous op's values.
            mem_rd_wr_d   = head_wr;
            mem_addr_d    = head_addr;
            mem_wr_data_d = head_wdata;
            state_d       = S_ISSUE;
          end else begin
            rsp_wr_d    = head_wr;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            state_d     = S_RESP;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = S_CAPTURE;
      S_CAPTURE: begin
        rsp_wr_d    = mem_rd_wr_q;
        rsp_rdata_d = mem_rd_wr_q ? '0 : mem_rd_data;
        rsp_err_d   = 1'b0;
        state_d     = S_RESP;
      end
      S_ERR_CLR: state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Error recovery takes priority over the normal memory-phase flow,
    // including a capture that would otherwise complete this cycle.
    if (err_rise && is_mem_phase(state_q)) begin
      state_d     = S_ERR_CLR;
      rsp_wr_d    = mem_rd_wr_q;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      mem_rd_wr_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      rsp_wr_q      <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      err_prev_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_rd_wr_q   <= mem_rd_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      rsp_wr_q      <= rsp_wr_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      err_prev_q    <= err_prev_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all decoded from registers, none combinational from inputs
  // --------------------------------------------------------------------------
  assign req_ready     = !fifo_full;
  assign rsp_valid     = (state_q == S_RESP);
  assign rsp_wr        = rsp_wr_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign mem_en        = (state_q == S_ISSUE);
  assign mem_rd_wr     = mem_rd_wr_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wr_data   = mem_wr_data_q;
  assign mem_out_wr_en = mem_rd_wr_q && ((state_q == S_ISSUE) || (state_q == S_WAIT));
  assign mem_err_clr   = (state_q == S_ERR_CLR);
  assign busy          = (state_q != S_IDLE) || !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_req_sequencer
// Purpose  : Directed self-checking bench for mem_req_sequencer with a
//            behavioural 16x16 memory (registered read data) and
//            hand-computed expected responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_req_sequencer;
  import mem_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_wr;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_rd_wr;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wr_data;
  logic        mem_out_wr_en;
  logic [15:0] mem_rd_data = '0;
  logic        mem_error = 1'b0;
  logic        mem_err_clr;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int en_count = 0;
  int clr_count = 0;

  logic [15:0] mem_model [16];

  mem_req_sequencer #(
    .ADDR_WIDTH (4),
    .DATA_WIDTH (16),
    .MEM_DEPTH  (12),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wr        (req_wr),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_wr        (rsp_wr),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .mem_en        (mem_en),
    .mem_rd_wr     (mem_rd_wr),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_out_wr_en (mem_out_wr_en),
    .mem_rd_data   (mem_rd_data),
    .mem_error     (mem_error),
    .mem_err_clr   (mem_err_clr),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Behavioural memory: acts on the strobe edge, read data registered.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_rd_wr) mem_model[mem_addr] <= mem_wr_data;
      else           mem_rd_data <= mem_model[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (mem_en)      en_count++;
    if (mem_err_clr) clr_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input string tag);
    int k = 0;
    while (rsp_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check(tag, 32'(rsp_valid), 1);
  endtask

  task automatic expect_rsp(input string tag, input logic wr, input logic [15:0] rdata, input logic err);
    wait_rsp({tag, "_valid"});
    check({tag, "_wr"},    32'(rsp_wr),    32'(wr));
    check({tag, "_rdata"}, 32'(rsp_rdata), 32'(rdata));
    check({tag, "_err"},   32'(rsp_err),   32'(err));
    tick();
  endtask

  task automatic drive_req(input logic wr, input logic [3:0] addr, input logic [15:0] wdata);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  req_t reqs [5];
  int   en_snap;
  int   hits;

  initial begin
    for (int i = 0; i < 16; i++) mem_model[i] = '0;

    // ---------------- Reset state ----------------
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_mem_en",    32'(mem_en),    0);
    check("rst_busy",      32'(busy),      0);
    check("rst_mem_addr",  32'(mem_addr),  0);
    check("rst_err_clr",   32'(mem_err_clr), 0);
    reset = 1'b1;

    // ---------------- Write 3 <- BEEF, then read 3 ----------------
    rsp_ready = 1'b1;
    drive_req(1'b1, 4'd3, 16'hBEEF);
    tick();                                 // pushed; IDLE pops this cycle
    req_valid = 1'b0;
    tick();                                 // ISSUE
    check("wr_mem_en",      32'(mem_en),      1);
    check("wr_mem_addr",    32'(mem_addr),    3);
    check("wr_mem_wr_data", 32'(mem_wr_data), 32'hBEEF);
    check("wr_mem_rd_wr",   32'(mem_rd_wr),   1);
    tick();                                 // WAIT
    check("wr_wait_en",     32'(mem_en),        0);
    check("wr_wait_loop",   32'(mem_out_wr_en), 1);
    tick();                                 // CAPTURE
    check("wr_cap_loop",    32'(mem_out_wr_en), 0);
    tick();                                 // RESP
    check("wr_rsp_valid",   32'(rsp_valid), 1);
    check("wr_rsp_wr",      32'(rsp_wr),    1);
    check("wr_rsp_rdata",   32'(rsp_rdata), 0);
    check("wr_rsp_err",     32'(rsp_err),   0);
    tick();                                 // IDLE
    drive_req(1'b0, 4'd3, 16'h0000);
    tick();                                 // pop
    req_valid = 1'b0;
    tick();                                 // ISSUE
    check("rd_mem_en",      32'(mem_en),    1);
    check("rd_mem_rd_wr",   32'(mem_rd_wr), 0);
    tick();                                 // WAIT
    tick();                                 // CAPTURE
    check("rd_cap_valid",   32'(rsp_valid), 0);
    tick();                                 // RESP, 4 cycles after pop
    check("rd_rsp_valid",   32'(rsp_valid), 1);
    check("rd_rsp_rdata",   32'(rsp_rdata), 32'hBEEF);
    check("rd_rsp_err",     32'(rsp_err),   0);
    check("rd_rsp_wr",      32'(rsp_wr),    0);
    check("t1_en_pulses",   32'(en_count),  2);
    tick();

    // ---------------- Local reject: addr 13 with MEM_DEPTH 12 ----------------
    en_snap = en_count;
    drive_req(1'b0, 4'd13, 16'h0000);
    tick();                                 // pop
    req_valid = 1'b0;
    tick();                                 // RESP one cycle after pop
    check("rej_rsp_valid",  32'(rsp_valid), 1);
    check("rej_rsp_err",    32'(rsp_err),   1);
    check("rej_rsp_rdata",  32'(rsp_rdata), 0);
    check("rej_mem_addr",   32'(mem_addr),  3);
    tick();
    check("rej_no_en",      32'(en_count),  32'(en_snap));

    // ---------------- Back-pressure: 5 requests, rsp_ready low ----------------
    rsp_ready = 1'b0;
    reqs[0] = '{wr: 1'b0, addr: 4'd3,  wdata: 16'h0000};
    reqs[1] = '{wr: 1'b1, addr: 4'd5,  wdata: 16'h1111};
    reqs[2] = '{wr: 1'b0, addr: 4'd5,  wdata: 16'h0000};
    reqs[3] = '{wr: 1'b0, addr: 4'd14, wdata: 16'h0000};
    reqs[4] = '{wr: 1'b1, addr: 4'd11, wdata: 16'h2222};
    for (int i = 0; i < 5; i++) begin
      check("bp_ready_before_push", 32'(req_ready), 1);
      drive_req(reqs[i].wr, reqs[i].addr, reqs[i].wdata);
      tick();
    end
    req_valid = 1'b0;
    check("bp_ready_full",  32'(req_ready), 0);
    check("bp_first_rsp",   32'(rsp_valid), 1);

    // Hold in RESP for 10 cycles: payload stable, no new accesses.
    en_snap = en_count;
    for (int i = 0; i < 10; i++) begin
      check("hold_rsp_valid", 32'(rsp_valid), 1);
      check("hold_rsp_rdata", 32'(rsp_rdata), 32'hBEEF);
      tick();
    end
    check("hold_no_en",     32'(en_count), 32'(en_snap));

    rsp_ready = 1'b1;
    check("bpA_rdata",      32'(rsp_rdata), 32'hBEEF);
    check("bpA_err",        32'(rsp_err),   0);
    tick();                                 // IDLE popping from full
    check("bp_ready_on_pop", 32'(req_ready), 0);
    check("bp_busy",         32'(busy),      1);
    tick();
    check("bp_ready_after",  32'(req_ready), 1);
    expect_rsp("bpB", 1'b1, 16'h0000, 1'b0);
    expect_rsp("bpC", 1'b0, 16'h1111, 1'b0);
    expect_rsp("bpD", 1'b0, 16'h0000, 1'b1);
    expect_rsp("bpE", 1'b1, 16'h0000, 1'b0);
    check("bp_idle_busy",   32'(busy), 0);

    // ---------------- Memory error edge during WAIT ----------------
    drive_req(1'b0, 4'd3, 16'h0000);
    tick();                                 // pop
    req_valid = 1'b0;
    tick();                                 // ISSUE
    check("err_issue_en",   32'(mem_en), 1);
    tick();                                 // WAIT
    mem_error = 1'b1;
    tick();                                 // ERR_CLR
    check("err_clr_pulse",  32'(mem_err_clr), 1);
    tick();                                 // RESP
    check("err_clr_single", 32'(mem_err_clr), 0);
    check("err_rsp_valid",  32'(rsp_valid), 1);
    check("err_rsp_err",    32'(rsp_err),   1);
    check("err_rsp_rdata",  32'(rsp_rdata), 0);
    tick();
    drive_req(1'b0, 4'd11, 16'h0000);
    tick();
    req_valid = 1'b0;
    expect_rsp("err_next", 1'b0, 16'h2222, 1'b0);
    check("err_clr_count",  32'(clr_count), 1);
    mem_error = 1'b0;
    tick();

    // ---------------- Reset during WAIT ----------------
    en_snap = en_count;
    drive_req(1'b1, 4'd7, 16'h7777);
    tick();                                 // pop first, push second
    drive_req(1'b0, 4'd7, 16'h0000);
    tick();                                 // ISSUE
    req_valid = 1'b0;
    check("rr_busy",        32'(busy), 1);
    tick();                                 // WAIT
    check("rr_wait_loop",   32'(mem_out_wr_en), 1);
    reset = 1'b0;
    #1;
    check("rr_mem_en",      32'(mem_en),        0);
    check("rr_loop",        32'(mem_out_wr_en), 0);
    check("rr_mem_addr",    32'(mem_addr),      0);
    check("rr_mem_wdata",   32'(mem_wr_data),   0);
    check("rr_busy_low",    32'(busy),          0);
    check("rr_req_ready",   32'(req_ready),     1);
    tick();
    tick();
    reset = 1'b1;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid === 1'b1 || mem_en === 1'b1) hits++;
    end
    check("rr_no_response", 32'(hits), 0);
    check("rr_fifo_empty",  32'(busy), 0);
    check("rr_en_count",    32'(en_count), 32'(en_snap + 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
